wb_dual_master_arbiter: RTL

- Shares one WISHBONE slave bus (22-bit address, 32-bit data) between two masters.
- Master 0 is the serial board-manager bridge; master 1 is a second host, e.g. the JTAG/PCIe register master.
- Uses round-robin grant, holds the grant for the whole cycle, and has an optional bus-timeout watchdog so a dead slave cannot hang a master.
- Sits between the masters and the register-space interconnect.

---
 rtl/wb_dual_master_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/wb_dual_master_arbiter.sv
// wb_dual_master_arbiter: round-robin WISHBONE arbiter sharing one slave bus between two masters.
// Define WB_ARB_TIMEOUT_EN to build in the bus-timeout watchdog.
module wb_dual_master_arbiter #(
  parameter int ADR_W   = 22,
  parameter int DAT_W   = 32,
  parameter int SEL_W   = DAT_W / 8,
  parameter int TIMEOUT = 1023
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic             m0_rty_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             m1_rty_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  output logic [SEL_W-1:0] s_sel_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic             s_rty_i,
  output logic [1:0]       grant_o,
  output logic [7:0]       timeout_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_e;

  state_e state_q, state_d;
  logic   last_owner_q, last_owner_d;
  logic   own0, own1;
  logic   stb_raw, fire;
  logic   ack_g, err_g, rty_g;

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must be within 2..65535");
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // A tie in IDLE goes to whichever master did not own the bus last.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_owner_q)) begin
          state_d      = OWN0;
          last_owner_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d      = OWN1;
          last_owner_d = 1'b1;
        end
      end
      OWN0: if (!m0_cyc_i) state_d = IDLE;
      OWN1: if (!m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign own0    = (state_q == OWN0);
  assign own1    = (state_q == OWN1);
  assign grant_o = {own1, own0};

  always_comb begin
    s_cyc_o = 1'b0;
    stb_raw = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    unique case (1'b1)
      own0: begin
        s_cyc_o = m0_cyc_i;
        stb_raw = m0_cyc_i & m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
      end
      own1: begin
        s_cyc_o = m1_cyc_i;
        stb_raw = m1_cyc_i & m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
      end
      default: ;
    endcase
  end

  // A forced timeout withdraws stb, which also drops any same-cycle termination.
  assign s_stb_o = stb_raw & ~fire;
  assign ack_g   = s_ack_i & s_stb_o;
  assign err_g   = (s_err_i & s_stb_o) | fire;
  assign rty_g   = s_rty_i & s_stb_o;

  assign m0_ack_o = own0 & ack_g;
  assign m0_err_o = own0 & err_g;
  assign m0_rty_o = own0 & rty_g;
  assign m0_dat_o = own0 ? s_dat_i : '0;
  assign m1_ack_o = own1 & ack_g;
  assign m1_err_o = own1 & err_g;
  assign m1_rty_o = own1 & rty_g;
  assign m1_dat_o = own1 ? s_dat_i : '0;

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        term;

  assign term = s_ack_i | s_err_i | s_rty_i;
  assign fire = stb_raw && (wd_q == TIMEOUT[15:0]);

  always_comb begin
    wd_d   = '0;
    tcnt_d = tcnt_q;
    if (fire) begin
      if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
    end else if (stb_raw && !term && state_d == state_q) begin
      wd_d = wd_q + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wd_q   <= '0;
      tcnt_q <= '0;
    end else begin
      wd_q   <= wd_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign timeout_cnt_o = tcnt_q;
`else
  assign fire          = 1'b0;
  assign timeout_cnt_o = '0;
`endif

endmodule
